// File: rtl/mbf_tap_scheduler_pkg.sv
// Shared types, default sizing and address helper for the MBF tap scheduler.
package mbf_pkg;

  localparam int unsigned MBF_N_OUT  = 527;
  localparam int unsigned MBF_N_TAP  = 32;
  localparam int unsigned MBF_N_BANK = 4;
  localparam int unsigned MBF_ADDR_W = 10;
  localparam int unsigned MBF_TAP_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LPF   = 2'd1,
    ST_HPF   = 2'd2,
    ST_DRAIN = 2'd3
  } mbf_state_e;

  typedef struct packed {
    logic [31:0] bank;
    logic [31:0] word;
  } mbf_addr_t;

  // Sample index n - k, offset by the N_TAP-1 zero words padded in front of memory.
  function automatic mbf_addr_t mbf_addr(input int unsigned n, input int unsigned k,
                                         input int unsigned n_tap, input int unsigned bank_w);
    int unsigned a;
    mbf_addr_t   r;
    a      = n + (n_tap - 1) - k;
    r.bank = a & ((32'd1 << bank_w) - 32'd1);
    r.word = a >> bank_w;
    return r;
  endfunction

endpackage

// File: rtl/mbf_tap_scheduler_if.sv
// Control/read/MAC bundle between the MBF tap scheduler (master) and the MBF datapath (slave).
interface mbf_tap_scheduler_if #(
  parameter int unsigned BANK_W = 2,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned TAP_W  = 5
);
  // start is a single-cycle request taken only while busy and done are both low;
  // hold is a level stall: while high no rd_en is issued, in-flight reads still finish.
  logic              start;
  logic              hold;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [BANK_W-1:0] rd_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic [TAP_W-1:0]  coef_idx;
  logic              acc_en;
  logic              acc_first;
  logic              acc_sel;
  logic              y_valid;
  logic              z_valid;
  logic [15:0]       stall_cnt;

  modport master (
    input  start, hold,
    output busy, done, rd_en, rd_bank, rd_addr, coef_idx,
           acc_en, acc_first, acc_sel, y_valid, z_valid, stall_cnt
  );

  modport slave (
    output start, hold,
    input  busy, done, rd_en, rd_bank, rd_addr, coef_idx,
           acc_en, acc_first, acc_sel, y_valid, z_valid, stall_cnt
  );
endinterface

// File: rtl/mbf_tap_scheduler_addr_gen.sv
// Maps (n, k) to bank/word read address and registers the stage-1 MAC controls.
module mbf_addr_gen
  import mbf_pkg::*;
#(
  parameter int unsigned N_TAP  = MBF_N_TAP,
  parameter int unsigned BANK_W = 2,
  parameter int unsigned ADDR_W = MBF_ADDR_W,
  parameter int unsigned TAP_W  = MBF_TAP_W,
  parameter int unsigned N_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue,
  input  logic              pass,
  input  logic [N_W-1:0]    n,
  input  logic [TAP_W-1:0]  k,
  output logic [BANK_W-1:0] rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [TAP_W-1:0]  coef_idx,
  output logic              acc_first,
  output logic              acc_sel
);

  mbf_addr_t addr_s;
  logic      acc_first_d, acc_first_q;
  logic      acc_sel_d, acc_sel_q;

  // Read-side outputs are forced to zero whenever no read is issued.
  always_comb begin
    addr_s      = mbf_addr(32'(n), 32'(k), N_TAP, BANK_W);
    rd_bank     = '0;
    rd_addr     = '0;
    coef_idx    = '0;
    if (issue) begin
      rd_bank  = BANK_W'(addr_s.bank);
      rd_addr  = ADDR_W'(addr_s.word);
      coef_idx = k;
    end
    acc_first_d = issue && (k == '0);
    acc_sel_d   = issue && pass;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_first_q <= 1'b0;
      acc_sel_q   <= 1'b0;
    end else begin
      acc_first_q <= acc_first_d;
      acc_sel_q   <= acc_sel_d;
    end
  end

  assign acc_first = acc_first_q;
  assign acc_sel   = acc_sel_q;

endmodule

// File: rtl/mbf_tap_scheduler.sv
// MBF tap scheduler: per output n runs an LPF then an HPF pass of N_TAP reads on one shared MAC.
// Optional stall cycle counter enabled by defining MBF_STALL_CNT_EN.
module mbf_tap_scheduler
  import mbf_pkg::*;
#(
  parameter int unsigned N_OUT  = MBF_N_OUT,
  parameter int unsigned N_TAP  = MBF_N_TAP,
  parameter int unsigned N_BANK = MBF_N_BANK,
  parameter int unsigned ADDR_W = MBF_ADDR_W,
  parameter int unsigned TAP_W  = MBF_TAP_W
) (
  input  logic                 clk,
  input  logic                 reset,
  mbf_tap_scheduler_if.master  bus,
  output mbf_state_e           dbg_state
);

  localparam int unsigned BANK_W = $clog2(N_BANK);
  localparam int unsigned N_W    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [TAP_W-1:0] K_LAST = TAP_W'(N_TAP - 1);
  localparam logic [N_W-1:0]   N_LAST = N_W'(N_OUT - 1);

  mbf_state_e       state_d, state_q;
  logic [N_W-1:0]   n_d, n_q;
  logic [TAP_W-1:0] k_d, k_q;
  logic             drain_d, drain_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             acc_en_d, acc_en_q;
  logic             acc_last_d, acc_last_q;
  logic             y_valid_d, y_valid_q;
  logic             z_valid_d, z_valid_q;

  logic             issue, last_tap, last_n, start_ok;
  logic             acc_first_s, acc_sel_s;
  logic [BANK_W-1:0] rd_bank_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [TAP_W-1:0]  coef_idx_s;

  always_comb begin
    issue    = ((state_q == ST_LPF) || (state_q == ST_HPF)) && !bus.hold;
    last_tap = (k_q == K_LAST);
    last_n   = (n_q == N_LAST);
    // done_q covers the cycle busy has just fallen, where a new start is still refused.
    start_ok = bus.start && (state_q == ST_IDLE) && !done_q;

    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    drain_d = drain_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_LPF;
          n_d     = '0;
          k_d     = '0;
        end
      end
      ST_LPF, ST_HPF: begin
        if (issue) begin
          if (!last_tap) begin
            k_d = k_q + TAP_W'(1);
          end else begin
            k_d = '0;
            if (state_q == ST_LPF) begin
              state_d = ST_HPF;
            end else if (!last_n) begin
              state_d = ST_LPF;
              n_d     = n_q + N_W'(1);
            end else begin
              state_d = ST_DRAIN;
              drain_d = 1'b0;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          drain_d = 1'b0;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d     = (state_d != ST_IDLE);
    acc_en_d   = issue;
    acc_last_d = issue && last_tap;
    y_valid_d  = acc_en_q && acc_last_q && !acc_sel_s;
    z_valid_d  = acc_en_q && acc_last_q && acc_sel_s;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      k_q        <= '0;
      drain_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      acc_en_q   <= 1'b0;
      acc_last_q <= 1'b0;
      y_valid_q  <= 1'b0;
      z_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      k_q        <= k_d;
      drain_q    <= drain_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      acc_en_q   <= acc_en_d;
      acc_last_q <= acc_last_d;
      y_valid_q  <= y_valid_d;
      z_valid_q  <= z_valid_d;
    end
  end

  mbf_addr_gen #(
    .N_TAP (N_TAP),
    .BANK_W(BANK_W),
    .ADDR_W(ADDR_W),
    .TAP_W (TAP_W),
    .N_W   (N_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .issue    (issue),
    .pass     (state_q == ST_HPF),
    .n        (n_q),
    .k        (k_q),
    .rd_bank  (rd_bank_s),
    .rd_addr  (rd_addr_s),
    .coef_idx (coef_idx_s),
    .acc_first(acc_first_s),
    .acc_sel  (acc_sel_s)
  );

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_en     = issue;
  assign bus.rd_bank   = rd_bank_s;
  assign bus.rd_addr   = rd_addr_s;
  assign bus.coef_idx  = coef_idx_s;
  assign bus.acc_en    = acc_en_q;
  assign bus.acc_first = acc_first_s;
  assign bus.acc_sel   = acc_sel_s;
  assign bus.y_valid   = y_valid_q;
  assign bus.z_valid   = z_valid_q;
  assign dbg_state     = state_q;

`ifdef MBF_STALL_CNT_EN
  logic [15:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_ok) begin
      stall_cnt_d = '0;
    end else if (busy_q && bus.hold && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule
